// File: rtl/ahb_split_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_split_arbiter_if
// Description : Bus-side signal bundle for the SPLIT-aware AHB arbiter.
//               The master modport is the arbiter's view; the slave modport
//               is the view of the bus fabric / masters that drive it.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_split_arbiter_if #(
    parameter int NO_OF_MASTERS = 4
);
    localparam int MW = $clog2(NO_OF_MASTERS);

    logic [NO_OF_MASTERS-1:0] HBUSREQ;
    logic [NO_OF_MASTERS-1:0] HLOCK;
    logic                     HREADY;
    logic [1:0]               HRESP;
    logic [NO_OF_MASTERS-1:0] HSPLIT;
    logic [NO_OF_MASTERS-1:0] HGRANT;
    logic [MW-1:0]            HMASTER;
    logic                     HMASTLOCK;
    logic [NO_OF_MASTERS-1:0] split_mask;

    // Arbiter side: samples requests/responses, drives grant and ownership.
    modport master (
        input  HBUSREQ, HLOCK, HREADY, HRESP, HSPLIT,
        output HGRANT, HMASTER, HMASTLOCK, split_mask
    );

    // Fabric side: drives requests/responses, observes grant and ownership.
    modport slave (
        output HBUSREQ, HLOCK, HREADY, HRESP, HSPLIT,
        input  HGRANT, HMASTER, HMASTLOCK, split_mask
    );
endinterface
`default_nettype wire

// File: rtl/ahb_split_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ahb_split_arbiter
// Description : Round-robin AHB arbiter that removes SPLIT masters from
//               arbitration until their HSPLIT bit re-enables them. Parks
//               on DEFAULT_MASTER (or the lowest unmasked master) when idle.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_split_arbiter #(
    parameter int NO_OF_MASTERS  = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_split_arbiter_if.master  bus
);
    localparam int MW = $clog2(NO_OF_MASTERS);

    localparam logic [1:0]               c_resp_split = 2'd3;
    localparam logic [NO_OF_MASTERS-1:0] c_one        = {{(NO_OF_MASTERS-1){1'b0}}, 1'b1};

    logic [NO_OF_MASTERS-1:0] r_hgrant;
    logic [MW-1:0]            r_hmaster;
    logic                     r_hmastlock;
    logic [NO_OF_MASTERS-1:0] r_split_mask;
    logic [MW-1:0]            r_rr_ptr;
    logic [MW-1:0]            r_dp_master;

    logic                     w_split;
    logic                     w_update;
    logic [NO_OF_MASTERS-1:0] w_split_set;
    logic [NO_OF_MASTERS-1:0] w_arb_mask;
    logic [NO_OF_MASTERS-1:0] w_eligible;
    logic                     w_lock_hold;
    logic                     w_rr_found;
    logic [MW-1:0]            w_rr_idx;
    logic                     w_park_found;
    logic [MW-1:0]            w_park_idx;
    logic                     w_gnt_valid;
    logic [MW-1:0]            w_gnt_idx;
    logic [MW-1:0]            w_addr_master;
    logic [NO_OF_MASTERS-1:0] w_next_grant;
    logic [MW-1:0]            w_next_rr;

    // A SPLIT is only meaningful in the wait state of a data phase; the
    // master being split is excluded from the arbitration on that same edge.
    assign w_split     = !bus.HREADY && (bus.HRESP == c_resp_split);
    assign w_update    = bus.HREADY || w_split;
    assign w_split_set = w_split ? (c_one << r_dp_master) : '0;
    assign w_arb_mask  = r_split_mask | w_split_set;
    assign w_eligible  = bus.HBUSREQ & ~w_arb_mask;

    // A locked sequence keeps the bus unless its own transfer is being split.
    assign w_lock_hold = r_hmastlock && bus.HLOCK[r_hmaster] &&
                         !(w_split && (r_dp_master == r_hmaster));

    // Round-robin search starting just after the last request-granted master.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_rr_ptr;
        for (int k = 1; k <= NO_OF_MASTERS; k++) begin
            if (!w_rr_found && w_eligible[MW'((int'(r_rr_ptr) + k) % NO_OF_MASTERS)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = MW'((int'(r_rr_ptr) + k) % NO_OF_MASTERS);
            end
        end
    end

    // Parking choice: default master if unmasked, else lowest unmasked one.
    always_comb begin
        w_park_found = 1'b0;
        w_park_idx   = '0;
        for (int i = NO_OF_MASTERS - 1; i >= 0; i--) begin
            if (!w_arb_mask[MW'(i)]) begin
                w_park_found = 1'b1;
                w_park_idx   = MW'(i);
            end
        end
        if (!w_arb_mask[DEFAULT_MASTER]) begin
            w_park_found = 1'b1;
            w_park_idx   = MW'(DEFAULT_MASTER);
        end
    end

    // Index of the currently granted master (grant is one-hot or zero).
    always_comb begin
        w_gnt_valid = |r_hgrant;
        w_gnt_idx   = '0;
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            if (r_hgrant[MW'(i)]) begin
                w_gnt_idx = MW'(i);
            end
        end
    end

    // With no grant outstanding the address phase stays with its last owner.
    assign w_addr_master = w_gnt_valid ? w_gnt_idx : r_hmaster;

    // Next grant and round-robin pointer; frozen outside update edges.
    always_comb begin
        w_next_grant = r_hgrant;
        w_next_rr    = r_rr_ptr;
        if (w_update && !w_lock_hold) begin
            if (w_rr_found) begin
                w_next_grant = c_one << w_rr_idx;
                w_next_rr    = w_rr_idx;
            end else if (w_park_found) begin
                w_next_grant = c_one << w_park_idx;
            end else begin
                w_next_grant = '0;
            end
        end
    end

    // Grant, ownership pipeline and split mask registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_hgrant     <= c_one << DEFAULT_MASTER;
            r_hmaster    <= MW'(DEFAULT_MASTER);
            r_hmastlock  <= 1'b0;
            r_split_mask <= '0;
            r_rr_ptr     <= MW'(DEFAULT_MASTER);
            r_dp_master  <= MW'(DEFAULT_MASTER);
        end else begin
            r_hgrant     <= w_next_grant;
            r_rr_ptr     <= w_next_rr;
            // Set has priority over a same-edge release of the same bit.
            r_split_mask <= (r_split_mask & ~bus.HSPLIT) | w_split_set;
            if (bus.HREADY) begin
                r_hmaster   <= w_addr_master;
                r_hmastlock <= bus.HLOCK[w_addr_master];
                r_dp_master <= r_hmaster;
            end else if (w_split) begin
                r_hmastlock <= 1'b0;
            end
        end
    end

    assign bus.HGRANT     = r_hgrant;
    assign bus.HMASTER    = r_hmaster;
    assign bus.HMASTLOCK  = r_hmastlock;
    assign bus.split_mask = r_split_mask;
endmodule
`default_nettype wire
